// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader
// Brief    : Boot loader that parses a length-prefixed, checksummed byte
//            frame and writes the assembled words into the instruction ROM.
// Revision : 1.0 - initial release
// ============================================================================
module rom_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MEM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   output logic        rx_ready_o,
   output logic        w_en_o,
   output logic [31:0] w_addr_o,
   output logic [31:0] w_data_o,
   output logic        busy_o,
   output logic        cpu_hold_o,
   output logic        done_o,
   output logic        err_o,
   output logic [1:0]  err_code_o
);

   localparam logic [31:0] c_mem_words = 32'(MEM_WORDS);
   localparam logic [1:0]  c_err_len   = 2'b01;
   localparam logic [1:0]  c_err_csum  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [1:0]  r_idx;
   logic [31:0] r_len;
   logic [31:0] r_cnt;
   logic [7:0]  r_sum;
   logic [23:0] r_word;
   logic        r_w_en;
   logic [31:0] r_w_addr;
   logic [31:0] r_w_data;
   logic        r_done;
   logic        r_err;
   logic [1:0]  r_err_code;

   logic        w_busy;
   logic        w_xfer;
   logic        w_start;
   logic        w_last_byte;
   logic        w_last_word;
   logic [31:0] w_len_full;

   assign w_busy      = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
   assign w_xfer      = rx_valid_i && w_busy;
   assign w_start     = start_i && !w_busy;
   assign w_last_byte = (r_idx == 2'd3);
   assign w_last_word = (r_cnt == r_len - 32'd1);
   // Length as it stands once the current (4th) length byte is merged in
   assign w_len_full  = {rx_data_i, r_len[23:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start_i) begin
               w_next = S_LEN;
            end
         end
         S_LEN: begin
            if (w_xfer && w_last_byte) begin
               if (w_len_full > c_mem_words) begin
                  w_next = S_ERR;
               end else if (w_len_full == 32'd0) begin
                  w_next = S_CSUM;
               end else begin
                  w_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (w_xfer && w_last_byte && w_last_word) begin
               w_next = S_CSUM;
            end
         end
         S_CSUM: begin
            if (w_xfer) begin
               w_next = (rx_data_i == r_sum) ? S_DONE : S_ERR;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx      <= 2'd0;
         r_len      <= 32'd0;
         r_cnt      <= 32'd0;
         r_sum      <= 8'd0;
         r_word     <= 24'd0;
         r_w_en     <= 1'b0;
         r_w_addr   <= 32'd0;
         r_w_data   <= 32'd0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= 2'b00;
      end else begin
         r_w_en <= 1'b0;
         if (w_start) begin
            r_idx      <= 2'd0;
            r_len      <= 32'd0;
            r_cnt      <= 32'd0;
            r_sum      <= 8'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
         end
         if (w_xfer) begin
            case (r_state)
               S_LEN: begin
                  r_idx <= r_idx + 2'd1;
                  case (r_idx)
                     2'd0:    r_len[7:0]   <= rx_data_i;
                     2'd1:    r_len[15:8]  <= rx_data_i;
                     2'd2:    r_len[23:16] <= rx_data_i;
                     default: r_len[31:24] <= rx_data_i;
                  endcase
                  if (w_last_byte && (w_len_full > c_mem_words)) begin
                     r_err      <= 1'b1;
                     r_err_code <= c_err_len;
                  end
               end
               S_DATA: begin
                  r_idx <= r_idx + 2'd1;
                  r_sum <= r_sum + rx_data_i;
                  case (r_idx)
                     2'd0:    r_word[7:0]   <= rx_data_i;
                     2'd1:    r_word[15:8]  <= rx_data_i;
                     2'd2:    r_word[23:16] <= rx_data_i;
                     default: begin
                        r_w_en   <= 1'b1;
                        r_w_addr <= BASE_ADDR + (r_cnt << 2);
                        r_w_data <= {rx_data_i, r_word};
                        r_cnt    <= r_cnt + 32'd1;
                     end
                  endcase
               end
               S_CSUM: begin
                  if (rx_data_i == r_sum) begin
                     r_done <= 1'b1;
                  end else begin
                     r_err      <= 1'b1;
                     r_err_code <= c_err_csum;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign rx_ready_o = w_busy;
   assign busy_o     = w_busy;
   assign cpu_hold_o = w_busy;
   assign w_en_o     = r_w_en;
   assign w_addr_o   = r_w_addr;
   assign w_data_o   = r_w_data;
   assign done_o     = r_done;
   assign err_o      = r_err;
   assign err_code_o = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_loader
// Brief    : Directed self-checking bench for rom_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        rx_valid_i;
   logic [7:0]  rx_data_i;
   logic        rx_ready_o;
   logic        w_en_o;
   logic [31:0] w_addr_o;
   logic [31:0] w_data_o;
   logic        busy_o;
   logic        cpu_hold_o;
   logic        done_o;
   logic        err_o;
   logic [1:0]  err_code_o;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          xfer_cyc[$];
   int          wr_cyc[$];
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic [7:0]  frm[$];
   logic [31:0] exp_addr[2] = '{32'h0000_0000, 32'h0000_0004};
   logic [31:0] exp_data[2] = '{32'h0010_0513, 32'h0020_0593};

   rom_loader #(
      .BASE_ADDR (32'h0000_0000),
      .MEM_WORDS (4096)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .rx_valid_i (rx_valid_i),
      .rx_data_i  (rx_data_i),
      .rx_ready_o (rx_ready_o),
      .w_en_o     (w_en_o),
      .w_addr_o   (w_addr_o),
      .w_data_o   (w_data_o),
      .busy_o     (busy_o),
      .cpu_hold_o (cpu_hold_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .err_code_o (err_code_o)
   );

   always #5 clk = ~clk;

   // Logs byte transfers and write strobes with the cycle they occupy
   always @(posedge clk) begin
      if (rx_valid_i && rx_ready_o) xfer_cyc.push_back(cyc);
      if (w_en_o) begin
         wr_cyc.push_back(cyc);
         wr_addr.push_back(w_addr_o);
         wr_data.push_back(w_data_o);
      end
      cyc = cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      xfer_cyc.delete();
      wr_cyc.delete();
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok         = 1'b0;
      rx_valid_i = 1'b1;
      rx_data_i  = b;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rx_ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      rx_valid_i = 1'b0;
      if (!ok) chk("rx_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_frame(input int maxgap, input int stray_at);
      foreach (frm[i]) begin
         if (maxgap > 0) begin
            repeat ($urandom_range(maxgap, 0)) begin
               @(posedge clk);
               #1;
            end
         end
         if (i == stray_at) begin
            start_i = 1'b1;
            @(posedge clk);
            #1;
            start_i = 1'b0;
         end
         send_byte(frm[i]);
      end
   endtask

   task automatic do_start();
      clear_logs();
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      @(negedge clk);
      chk("busy_after_start", 32'(busy_o), 32'd1);
      chk("ready_after_start", 32'(rx_ready_o), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_result(input string tag, input logic d, input logic e, input logic [1:0] code);
      @(negedge clk);
      chk({tag, "_done"}, 32'(done_o), 32'(d));
      chk({tag, "_err"}, 32'(err_o), 32'(e));
      chk({tag, "_code"}, 32'(err_code_o), 32'(code));
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_hold"}, 32'(cpu_hold_o), 32'd0);
      chk({tag, "_ready"}, 32'(rx_ready_o), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_nominal_writes(input string tag);
      chk({tag, "_wr_count"}, 32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() == 2 && xfer_cyc.size() >= 12) begin
         for (int k = 0; k < 2; k++) begin
            chk({tag, "_wr_addr"}, wr_addr[k], exp_addr[k]);
            chk({tag, "_wr_data"}, wr_data[k], exp_data[k]);
            chk({tag, "_wr_latency"}, 32'(wr_cyc[k] - xfer_cyc[7 + 4 * k]), 32'd1);
         end
      end
   endtask

   task automatic load_nominal(input logic [7:0] csum);
      frm = '{8'h02, 8'h00, 8'h00, 8'h00,
              8'h13, 8'h05, 8'h10, 8'h00,
              8'h93, 8'h05, 8'h20, 8'h00, csum};
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(rx_ready_o), 32'd0);
      chk({tag, "_wen"}, 32'(w_en_o), 32'd0);
      chk({tag, "_waddr"}, w_addr_o, 32'd0);
      chk({tag, "_wdata"}, w_data_o, 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_hold"}, 32'(cpu_hold_o), 32'd0);
      chk({tag, "_done"}, 32'(done_o), 32'd0);
      chk({tag, "_err"}, 32'(err_o), 32'd0);
      chk({tag, "_code"}, 32'(err_code_o), 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      start_i    = 1'b0;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;

      // Nominal two-word load, back-to-back bytes
      do_start();
      load_nominal(8'hE0);
      send_frame(0, -1);
      check_result("nominal", 1'b1, 1'b0, 2'b00);
      check_nominal_writes("nominal");
      chk("nominal_addr_hold", w_addr_o, 32'h0000_0004);
      chk("nominal_data_hold", w_data_o, 32'h0020_0593);

      // Zero-length frame
      do_start();
      frm = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(0, -1);
      check_result("zero_len", 1'b1, 1'b0, 2'b00);
      chk("zero_len_wr_count", 32'(wr_addr.size()), 32'd0);

      // Length overflow: N = 4097
      do_start();
      frm = '{8'h01, 8'h10, 8'h00, 8'h00};
      send_frame(0, -1);
      check_result("overflow", 1'b0, 1'b1, 2'b01);
      chk("overflow_wr_count", 32'(wr_addr.size()), 32'd0);

      // Checksum mismatch: writes still land
      do_start();
      load_nominal(8'hE1);
      send_frame(0, -1);
      check_result("csum_bad", 1'b0, 1'b1, 2'b10);
      check_nominal_writes("csum_bad");

      // Random rx gaps plus a stray start pulse in the middle of DATA
      do_start();
      load_nominal(8'hE0);
      send_frame(3, 6);
      check_result("backpressure", 1'b1, 1'b0, 2'b00);
      check_nominal_writes("backpressure");

      // Reset after two data bytes of word 0
      do_start();
      frm = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05};
      send_frame(0, -1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid_reset");
      repeat (6) @(posedge clk);
      #1;
      chk("mid_reset_wr_count", 32'(wr_addr.size()), 32'd0);

      do_start();
      load_nominal(8'hE0);
      send_frame(0, -1);
      check_result("after_reset", 1'b1, 1'b0, 2'b00);
      check_nominal_writes("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rom_loader.md
# rom_loader

Boot-time program loader. It drives the write port of the instruction ROM (word write enable, byte address, 32-bit data) from a byte stream supplied by a serial receiver over a valid/ready handshake. It parses a length-prefixed, checksummed frame and writes each assembled word to consecutive ROM addresses. It holds the CPU in reset while a load is in progress.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written
- MEM_WORDS, 4096, ROM capacity in 32-bit words; larger lengths are rejected

Ports:
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- start_i  in  1  one-cycle pulse that begins a load session; ignored while busy_o=1
- rx_valid_i  in  1  byte available
- rx_data_i  in  8  byte value
- rx_ready_o  out  1  loader accepts a byte; a transfer occurs when rx_valid_i & rx_ready_o
- w_en_o  out  1  ROM word write strobe, one cycle per word
- w_addr_o  out  32  ROM byte address, always word-aligned
- w_data_o  out  32  ROM write data
- busy_o  out  1  session in progress
- cpu_hold_o  out  1  equals busy_o; keeps the core in reset
- done_o  out  1  sticky: last session completed with a good checksum
- err_o  out  1  sticky: last session failed
- err_code_o  out  2  2'b01 length overflow, 2'b10 checksum mismatch, 2'b00 none

## Operation
- Frame format: 4 length bytes N (count of words, little-endian), then N×4 data bytes, then 1 checksum byte.
- Data words are little-endian: the first byte goes to [7:0].
- Checksum is the 8-bit sum, mod 256, of the data bytes only. Length bytes are excluded.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE: start_i moves to LEN. The pulse clears done_o, err_o, err_code_o, byte index, word counter and checksum.
- DONE and ERR: behave like IDLE with respect to start_i.
- LEN: accepts 4 bytes. After the 4th byte:
  - N > MEM_WORDS: go to ERR with code 01.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA: a 2-bit byte index assembles each word.
  - On the 4th byte, register the write: address = BASE_ADDR + 4×k, where k is the word count starting at 0; data = assembled word.
  - After word N-1, go to CSUM.
- CSUM: accepts 1 byte.
  - Equal to the running sum: go to DONE.
  - Otherwise: go to ERR with code 10.
  - Words already written are not rolled back.
- rx_ready_o = 1 only in LEN, DATA and CSUM.
- busy_o = 1 in LEN, DATA and CSUM.
- start_i while busy: ignored, with no effect on the session.
- Address arithmetic is 32-bit. Only the low 2 bits of the byte index wrap; the word counter is as wide as the 32-bit length.

## Timing
- Reset values: rx_ready_o=0, w_en_o=0, w_addr_o=0, w_data_o=0, busy_o=0, cpu_hold_o=0, done_o=0, err_o=0, err_code_o=0. State returns to IDLE.
- Reset mid-session: the partial word is discarded, no further write is issued and the flags are cleared.
- start_i in cycle t: busy_o and rx_ready_o = 1 from cycle t+1.
- Write latency: if the 4th byte of a word transfers in cycle t, then w_en_o = 1 in cycle t+1 only, with w_addr_o/w_data_o valid in that cycle. w_addr_o/w_data_o hold their value afterwards.
- Back-to-back bytes (rx_valid_i=1 every cycle) are accepted at 1 byte/cycle with no bubbles. There is therefore at most one write every 4 cycles.
- Gaps in rx_valid_i stall the FSM with no state change.
- After the last length or checksum byte transfers in cycle t:
  - The new state is visible in t+1.
  - done_o or err_o rises in t+1.
  - busy_o, cpu_hold_o and rx_ready_o fall in t+1.
- In the cycle the final write strobe fires, the FSM is already in CSUM and rx_ready_o stays 1.

## Test plan
- Nominal 2-word load: start, then bytes 02 00 00 00, 13 05 10 00, 93 05 20 00, E0.
  - Required: writes (0x0, 0x00100513) and (0x4, 0x00200593), each one cycle after its 4th byte.
  - Then done_o=1, err_o=0, busy_o=0.
- Zero length: bytes 00 00 00 00, 00 → no w_en_o pulse; done_o=1.
- Overflow: bytes 01 10 00 00 (N=4097) → err_o=1, err_code_o=01, no writes, rx_ready_o=0.
- Checksum mismatch: nominal frame with final byte E1.
  - Required: both writes still occur; err_o=1, err_code_o=10, done_o=0.
- Backpressure and stray start: insert random rx_valid_i gaps and a start_i pulse mid-DATA.
  - Required: identical writes and result to the nominal case.
- Reset mid-word: assert rst after 2 data bytes of word 0.
  - Required: all outputs at their reset values next cycle, and no write.
  - A fresh nominal load afterwards succeeds.
